req_capture_server: RTL and testbench
=====================================

# req_capture_server

Edge-capturing request server that sits directly upstream of the 16-to-8 priority encoder stage. It turns 16 raw request lines into sticky pending flags. It then presents the highest-numbered pending request, one at a time, over a valid/ready handshake, using the same 8-bit code format as the encoder (`0000_iiii`, or `1111_0000` for none). A request is cleared only when the consumer accepts it, so short pulses are never lost.

## Interface
- `WIDTH`, 16, number of request lines; power of two, 2..16.
- `IDX_W`, `$clog2(WIDTH)`, index width; derived, not overridden.

- `clk`  in  1  single clock; all state on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_in`  in  WIDTH  raw request lines; a rising edge posts a request.
- `clr_all`  in  1  synchronous clear of all pending requests and overflow.
- `out_valid`  out  1  a request is being presented.
- `out_ready`  in  1  consumer accepts the presented request.
- `out_idx`  out  IDX_W  index of the presented request.
- `out_code`  out  8  `{4'b0000, out_idx}` when `out_valid`, else `8'hF0`.
- `pending`  out  WIDTH  current sticky pending flags.
- `overflow`  out  1  sticky; a rising edge arrived on an already-pending line.

## Operation
- Edge detect: `req_prev <= req_src` each cycle; `rise = req_src & ~req_prev`.
  - `req_src` is `req_in`, or its synchronised copy (see Configuration).
- Pending update, per bit, in priority order:
  - `clr_all` forces 0.
  - Otherwise `rise[i]` sets the bit.
  - Otherwise an accept of `i` clears it.
  - Otherwise the bit holds.
- Set beats accept-clear on the same bit in the same cycle. The bit stays pending and `overflow` is not set.
- `overflow` sets when `rise[i] & pending[i]` and bit `i` is not being accepted that cycle. It is cleared only by `clr_all` or reset.
- FSM, two states:
  - IDLE (`out_valid`=0): if `pending != 0` and `!clr_all`, latch the index of the highest set pending bit into `out_idx` and go to HOLD.
  - HOLD (`out_valid`=1): `out_idx` is frozen. If `clr_all`, go to IDLE. Else if `out_ready` (accept), clear `pending[out_idx]` and go to IDLE.
- A new higher-priority request arriving during HOLD does not preempt. It is served on the next IDLE→HOLD pass.
- The handshake follows valid/ready rules: `out_valid` never drops without an accept except on `clr_all` or reset. `out_idx` and `out_code` are stable while `out_valid & !out_ready`.
- Reset values:
  - `pending`=0, `req_prev`=0, `overflow`=0, state IDLE.
  - `out_valid`=0, `out_idx`=0, `out_code`=`8'hF0`.
  - Synchroniser flops are 0.
- Reset asserted mid-handshake: outputs return to reset values immediately (asynchronously). All pending requests are discarded.

## Timing
- All outputs are registered, or decoded only from registered state.
- Without the sync stage:
  - A `req_in` rise seen at edge E0 sets `pending` after E0.
  - `out_valid` rises after E1, so latency is 2 cycles.
- Accept at edge A: `out_valid`=0 after A. The next request is presented after A+1.
- Peak throughput is one request per 2 cycles.
- A line held high posts exactly one request. It must go low and rise again to post another.
- `clr_all` takes effect at the edge where it is sampled. Rises in that same cycle are dropped.

## Configuration
- `REQ_CAPTURE_SYNC_EN`
  - Defined: `req_in` passes through a 2-flop synchroniser per bit before edge detection. Input-to-`out_valid` latency becomes 4 cycles.
  - Undefined: `req_in` feeds edge detection directly, for inputs already synchronous to `clk`. Latency is 2 cycles.
  - All other behaviour is identical in both builds.

## Test plan
- Reset: drive `rst_n`=0 with `req_in`=`16'hFFFF` → `out_valid`=0, `out_code`=`8'hF0`, `pending`=0, `overflow`=0. Release with `req_in` still high → no request is posted.
- Single pulse: 1-cycle pulse on `req_in[5]`, `out_ready`=1 → `out_valid` after 2 cycles (4 with sync), `out_code`=`8'h05`. `pending[5]` clears the cycle after the accept.
- Priority and no-preempt: rise on bits 3 and 9 together, `out_ready`=0 → presents `8'h09`. Then rise on bit 15 during HOLD → `out_code` stays `8'h09` until accept. The next presentations are `8'h0F`, then `8'h03`.
- Backpressure: hold `out_ready`=0 for 10 cycles with request 7 presented → `out_valid`=1 and `out_idx`=7 are stable throughout.
- Overflow and collision:
  - Second rise on pending bit 2 before accept → `overflow`=1.
  - Rise on bit 2 in the same cycle it is accepted → `pending[2]` stays 1, and `overflow` is unchanged by that event.
- Clear: `clr_all` during HOLD with bits 1, 4 and 12 pending → next cycle `out_valid`=0, `pending`=0, `overflow`=0, `out_code`=`8'hF0`.

Source files
------------

// File: rtl/req_capture_server.sv
// Edge-capturing request server: sticky pending flags served highest-index-first over valid/ready.
// Optional build macro REQ_CAPTURE_SYNC_EN inserts a 2-flop synchroniser on req_in.
module req_capture_server #(
   parameter int WIDTH = 16,
   localparam int IDX_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] req_in,
   input  logic             clr_all,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_idx,
   output logic [7:0]       out_code,
   output logic [WIDTH-1:0] pending,
   output logic             overflow,
   output logic             state_dbg
);

   typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

   state_t           state;
   logic [WIDTH-1:0] req_src;
   logic [WIDTH-1:0] req_prev;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] acc_vec;
   logic [WIDTH-1:0] pending_nxt;
   logic [IDX_W-1:0] top_idx;
   logic             accept;
   logic             ovf_hit;
   logic             armed;

`ifdef REQ_CAPTURE_SYNC_EN
   localparam int ARM_D = 3;
   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= req_in;
         sync2 <= sync1;
      end
   end

   assign req_src = sync2;
`else
   localparam int ARM_D = 1;
   assign req_src = req_in;
`endif

   // Lines already high when reset releases must not look like fresh rises, so
   // edge detection is masked until req_prev has caught up with the input path.
   logic [ARM_D-1:0] arm_sr;
   assign armed = arm_sr[ARM_D-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arm_sr   <= '0;
         req_prev <= '0;
      end else begin
         arm_sr   <= (arm_sr << 1) | ARM_D'(1);
         req_prev <= req_src;
      end
   end

   // Handshake: out_valid holds with out_idx/out_code frozen until out_ready is
   // sampled high (accept); only clr_all or reset may withdraw it earlier.
   always_comb begin
      rise    = armed ? (req_src & ~req_prev) : '0;
      accept  = (state == HOLD) && out_ready && !clr_all;
      acc_vec = '0;
      if (accept) acc_vec[out_idx] = 1'b1;
      pending_nxt = clr_all ? '0 : ((pending & ~acc_vec) | rise);
      ovf_hit     = |(rise & pending & ~acc_vec);
      top_idx     = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (pending[i]) top_idx = IDX_W'(i);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending  <= '0;
         overflow <= 1'b0;
         state    <= IDLE;
         out_idx  <= '0;
      end else begin
         pending  <= pending_nxt;
         overflow <= clr_all ? 1'b0 : (overflow | ovf_hit);
         case (state)
            IDLE: begin
               if ((pending != '0) && !clr_all) begin
                  out_idx <= top_idx;
                  state   <= HOLD;
               end
            end
            HOLD: begin
               if (clr_all || out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign out_valid = (state == HOLD);
   assign state_dbg = state;
   assign out_code  = out_valid ? {4'b0000, 4'(out_idx)} : 8'hF0;

endmodule

// File: tb/tb_req_capture_server.sv
// Directed self-checking bench for req_capture_server (WIDTH=16), both sync builds.
module tb_req_capture_server;

`ifdef REQ_CAPTURE_SYNC_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 2;
`endif
   localparam int SYNC_D = LAT - 2;

   logic        clk;
   logic        rst_n;
   logic [15:0] req_in;
   logic        clr_all;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_idx;
   logic [7:0]  out_code;
   logic [15:0] pending;
   logic        overflow;
   logic        state_dbg;

   int n_tests = 0;
   int n_fail  = 0;

   req_capture_server dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_in    (req_in),
      .clr_all   (clr_all),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_idx   (out_idx),
      .out_code  (out_code),
      .pending   (pending),
      .overflow  (overflow),
      .state_dbg (state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // driver tasks
   task automatic tick(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse(input logic [15:0] mask);
      req_in = mask;
      tick();
      req_in = '0;
   endtask

   task automatic accept_one();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      req_in    = 16'hFFFF;
      clr_all   = 1'b0;
      out_ready = 1'b0;
      tick(3);

      // reset state with all lines high
      check("rst_valid", out_valid, 0);
      check("rst_code", out_code, 8'hF0);
      check("rst_pending", pending, 0);
      check("rst_overflow", overflow, 0);
      check("rst_idx", out_idx, 0);
      check("rst_state", state_dbg, 0);
      rst_n = 1'b1;
      tick(LAT + 4);
      check("rel_high_pending", pending, 0);
      check("rel_high_valid", out_valid, 0);
      req_in = '0;
      tick(LAT + 2);
      check("fall_pending", pending, 0);

      // single pulse, consumer always ready
      out_ready = 1'b1;
      pulse(16'h0020);
      tick(LAT - 2);
      check("pulse_not_yet", out_valid, 0);
      tick();
      check("pulse_valid", out_valid, 1);
      check("pulse_code", out_code, 8'h05);
      check("pulse_pending", pending, 16'h0020);
      tick();
      check("pulse_acc_valid", out_valid, 0);
      check("pulse_acc_pending", pending, 0);
      out_ready = 1'b0;
      tick(2);

      // priority and no preemption
      pulse(16'h0208);
      tick(LAT - 1);
      check("prio_code9", out_code, 8'h09);
      pulse(16'h8000);
      tick(LAT + 2);
      check("nopre_valid", out_valid, 1);
      check("nopre_code", out_code, 8'h09);
      check("nopre_pending", pending, 16'h8208);
      accept_one();
      check("prio_acc_valid", out_valid, 0);
      check("prio_acc_pending", pending, 16'h8008);
      tick();
      check("prio_code15", out_code, 8'h0F);
      accept_one();
      tick();
      check("prio_code3", out_code, 8'h03);
      accept_one();
      check("prio_empty", pending, 0);
      tick(2);

      // backpressure
      pulse(16'h0080);
      tick(LAT - 1);
      for (int i = 0; i < 10; i++) begin
         check("bp_valid", out_valid, 1);
         check("bp_idx", out_idx, 7);
         tick();
      end
      accept_one();
      check("bp_done", out_valid, 0);
      tick(2);

      // rise on bit 2 in the same cycle it is accepted
      pulse(16'h0004);
      tick(LAT - 1);
      check("coll_code", out_code, 8'h02);
      tick(LAT);
      req_in = 16'h0004;
      tick(SYNC_D);
      accept_one();
      check("coll_pending", pending, 16'h0004);
      check("coll_overflow", overflow, 0);
      check("coll_valid", out_valid, 0);
      tick();
      check("coll_repres", out_code, 8'h02);
      req_in = '0;
      tick(LAT);

      // second rise on a pending, unaccepted bit
      pulse(16'h0004);
      tick(LAT);
      check("ovf_set", overflow, 1);
      check("ovf_pending", pending, 16'h0004);
      check("ovf_still_idx", out_code, 8'h02);
      accept_one();
      check("ovf_sticky", overflow, 1);
      check("ovf_acc_pending", pending, 0);
      tick(2);

      // clr_all during HOLD
      pulse(16'h1012);
      tick(LAT - 1);
      check("clr_pre_code", out_code, 8'h0C);
      clr_all = 1'b1;
      tick();
      clr_all = 1'b0;
      check("clr_valid", out_valid, 0);
      check("clr_pending", pending, 0);
      check("clr_overflow", overflow, 0);
      check("clr_code", out_code, 8'hF0);

      // rise landing on the clr_all edge is dropped
      req_in = 16'h0040;
      tick(SYNC_D);
      clr_all = 1'b1;
      tick();
      clr_all = 1'b0;
      req_in = '0;
      tick(LAT + 1);
      check("clr_drop_pending", pending, 0);
      check("clr_drop_valid", out_valid, 0);

      // async reset mid-handshake
      pulse(16'h0400);
      tick(LAT - 1);
      check("arst_pre_code", out_code, 8'h0A);
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", out_valid, 0);
      check("arst_code", out_code, 8'hF0);
      check("arst_pending", pending, 0);
      check("arst_idx", out_idx, 0);
      tick();
      rst_n = 1'b1;
      tick(LAT + 2);
      check("arst_after", out_valid, 0);

      // final report
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected end before %0t", $time);
      $fatal(1);
   end

endmodule
